// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: 3-sample majority voting, valid/ready output and per-word error flags.
// Define UART_RX_BREAK_DET_EN to add the o_break output and break-frame suppression.
module uart_rx_core #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int OVS       = 16,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_rxd,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_frm_err,
    output logic              o_par_err,
    output logic              o_ovr,
`ifdef UART_RX_BREAK_DET_EN
    output logic              o_break,
`endif
    output logic              o_busy
);
    localparam int DIV    = (CLK_HZ + (BAUD * OVS) / 2) / (BAUD * OVS);
    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SUB_W  = $clog2(OVS);
    localparam int BIT_W  = $clog2(DATA_W + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
    localparam logic [SUB_W-1:0]  SMP_A     = SUB_W'(OVS / 2 - 1);
    localparam logic [SUB_W-1:0]  SMP_B     = SUB_W'(OVS / 2);
    localparam logic [SUB_W-1:0]  SMP_C     = SUB_W'(OVS / 2 + 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(OVS - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
`ifdef UART_RX_BREAK_DET_EN
        , ST_BREAK
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          rx_sync_q, rx_sync_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]          smp_q, smp_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_bit_q, par_bit_d;
    logic                frm_q, frm_d;
    logic                wait_high_q, wait_high_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                frm_err_q, frm_err_d;
    logic                par_err_q, par_err_d;
    logic                ovr_q, ovr_d;
`ifdef UART_RX_BREAK_DET_EN
    logic                break_q, break_d;
    logic                brk;
`endif

    logic rx_s, rx_fall, tick, maj, at_maj, at_end, done, par_err_now;

    // rx_sync_q[0..1] is the synchronizer; [2] is the previous synchronized value for edge detect.
    assign rx_sync_d   = {rx_sync_q[1:0], i_rxd};
    assign rx_s        = rx_sync_q[1];
    assign rx_fall     = rx_sync_q[2] & ~rx_sync_q[1];
    assign tick        = (tick_cnt_q == TICK_LAST);
    assign maj         = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign at_maj      = tick && (sub_q == SMP_C);
    assign at_end      = tick && (sub_q == SUB_LAST);
    assign par_err_now = (PARITY != 0) && (((^shift_q) ^ par_bit_q) != PAR_ODD);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        sub_d       = sub_q;
        bit_cnt_d   = bit_cnt_q;
        smp_d       = smp_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        frm_d       = frm_q;
        wait_high_d = wait_high_q & ~rx_s;
        done        = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk         = 1'b0;
`endif
        if (tick) begin
            sub_d = at_end ? '0 : sub_q + 1'b1;
            if (sub_q == SMP_A) smp_d[0] = rx_s;
            if (sub_q == SMP_B) smp_d[1] = rx_s;
        end

        unique case (state_q)
            ST_IDLE: begin
                sub_d = '0;
                if (rx_fall && !wait_high_q) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    par_bit_d  = 1'b0;
                    frm_d      = 1'b0;
                end
            end
            ST_START: begin
                if (at_maj && maj)  state_d = ST_IDLE;
                else if (at_end)    state_d = ST_DATA;
            end
            ST_DATA: begin
                if (at_maj) shift_d = {maj, shift_q[DATA_W-1:1]};
                if (at_end) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (at_maj) par_bit_d = maj;
                if (at_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // The last stop bit completes at its majority point so a back-to-back start edge is caught.
                if (at_maj) begin
                    frm_d = frm_q | ~maj;
                    if (bit_cnt_q == STOP_LAST) begin
                        done        = 1'b1;
                        state_d     = ST_IDLE;
                        wait_high_d = frm_q | ~maj;
                    end
`ifdef UART_RX_BREAK_DET_EN
                    if ((bit_cnt_q == '0) && (shift_q == '0) && !par_bit_q && !maj) begin
                        done        = 1'b0;
                        brk         = 1'b1;
                        state_d     = ST_BREAK;
                        wait_high_d = 1'b0;
                    end
`endif
                end
                if (at_end) bit_cnt_d = bit_cnt_q + 1'b1;
            end
`ifdef UART_RX_BREAK_DET_EN
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        frm_err_d = frm_err_q;
        par_err_d = par_err_q;
        valid_d   = valid_q;
        ovr_d     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        break_d   = brk;
`endif
        if (done) begin
            if (!valid_q || i_ready) begin
                data_d    = shift_q;
                frm_err_d = frm_d;
                par_err_d = par_err_now;
                valid_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q     <= ST_IDLE;
            rx_sync_q   <= 3'b111;
            tick_cnt_q  <= '0;
            sub_q       <= '0;
            bit_cnt_q   <= '0;
            smp_q       <= 2'b11;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            frm_q       <= 1'b0;
            wait_high_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frm_err_q   <= 1'b0;
            par_err_q   <= 1'b0;
            ovr_q       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_sync_q   <= rx_sync_d;
            tick_cnt_q  <= tick_cnt_d;
            sub_q       <= sub_d;
            bit_cnt_q   <= bit_cnt_d;
            smp_q       <= smp_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            frm_q       <= frm_d;
            wait_high_q <= wait_high_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frm_err_q   <= frm_err_d;
            par_err_q   <= par_err_d;
            ovr_q       <= ovr_d;
`ifdef UART_RX_BREAK_DET_EN
            break_q     <= break_d;
`endif
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_frm_err = frm_err_q;
    assign o_par_err = par_err_q;
    assign o_ovr     = ovr_q;
    assign o_busy    = (state_q != ST_IDLE);
`ifdef UART_RX_BREAK_DET_EN
    assign o_break   = break_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: a default 8N1 instance and a 7E2 instance on a faster line,
// line frames built from data/parity/stop rules and compared against a scoreboard of expected words.
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int CLK_HZ  = 50_000_000;
    localparam int D0_BAUD = 115_200;
    localparam int D0_OVS  = 16;
    localparam int D0_DIV  = (CLK_HZ + D0_BAUD * D0_OVS / 2) / (D0_BAUD * D0_OVS);
    localparam int D0_BIT  = D0_DIV * D0_OVS;
    localparam int D1_BAUD = 781_250;
    localparam int D1_OVS  = 8;
    localparam int D1_DIV  = (CLK_HZ + D1_BAUD * D1_OVS / 2) / (D1_BAUD * D1_OVS);
    localparam int D1_BIT  = D1_DIV * D1_OVS;
    // Clocks from the first driven start bit to the o_valid rise: 2 sync flops, 1 edge-detect cycle,
    // then ticks up to and including the majority tick of the stop bit (bit 9, sub-index OVS/2+1).
    localparam int T_DONE0 = 3 + D0_DIV * (9 * D0_OVS + D0_OVS / 2 + 2);

    logic clk = 1'b0;
    logic srst;
    logic rxd0, ready0, valid0, frm0, par0, ovr0, busy0;
    logic [7:0] data0;
    logic rxd1, ready1, valid1, frm1, par1, ovr1, busy1;
    logic [6:0] data1;
`ifdef UART_RX_BREAK_DET_EN
    logic brk0, brk1;
    int   brk_cnt0 = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ovr_cnt0 = 0;
    int rise0 = 0;
    logic valid0_prev = 1'b0;
    logic [10:0] act0[$], exp0[$], act1[$], exp1[$];

    always #5 clk = ~clk;

    uart_rx_core u_dut0 (
        .i_clk(clk), .i_srst(srst), .i_rxd(rxd0), .o_data(data0), .o_valid(valid0),
        .i_ready(ready0), .o_frm_err(frm0), .o_par_err(par0), .o_ovr(ovr0),
`ifdef UART_RX_BREAK_DET_EN
        .o_break(brk0),
`endif
        .o_busy(busy0)
    );

    uart_rx_core #(
        .CLK_HZ(CLK_HZ), .BAUD(D1_BAUD), .OVS(D1_OVS), .DATA_W(7), .PARITY(2), .STOP_BITS(2)
    ) u_dut1 (
        .i_clk(clk), .i_srst(srst), .i_rxd(rxd1), .o_data(data1), .o_valid(valid1),
        .i_ready(ready1), .o_frm_err(frm1), .o_par_err(par1), .o_ovr(ovr1),
`ifdef UART_RX_BREAK_DET_EN
        .o_break(brk1),
`endif
        .o_busy(busy1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: accepted words, overrun/break pulses, o_valid rise time.
    always @(negedge clk) begin
        if (valid0 && ready0) act0.push_back({frm0, par0, 1'b0, data0});
        if (valid1 && ready1) act1.push_back({frm1, par1, 2'b00, data1});
        if (ovr0) ovr_cnt0 <= ovr_cnt0 + 1;
`ifdef UART_RX_BREAK_DET_EN
        if (brk0) brk_cnt0 <= brk_cnt0 + 1;
`endif
        if (valid0 && !valid0_prev) rise0 <= cyc;
        valid0_prev <= valid0;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] pack(input logic frm, input logic par, input logic [8:0] d);
        return {frm, par, d};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rxd0 = v;
        else            rxd1 = v;
    endtask

    // Builds the line waveform: start 0, data LSB first, optional parity, stop bits (1 unless forced low).
    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int par_mode, input bit flip_par, input bit [1:0] stop_low,
                              input int nstop);
        logic line[$];
        logic p;
        int   bitclk;
        bitclk = (which == 0) ? D0_BIT : D1_BIT;
        p = 1'b0;
        line.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            line.push_back(data[i]);
            p ^= data[i];
        end
        if (par_mode != 0) line.push_back(((par_mode == 1) ? ~p : p) ^ flip_par);
        for (int i = 0; i < nstop; i++) line.push_back(~stop_low[i]);
        foreach (line[i]) begin
            drive(which, line[i]);
            step(bitclk);
        end
        drive(which, 1'b1);
    endtask

    task automatic drain_check(input int which, input string tag);
        if (which == 0) begin
            check({tag, " count"}, act0.size(), exp0.size());
            while (act0.size() > 0 && exp0.size() > 0) check(tag, act0.pop_front(), exp0.pop_front());
            act0.delete();
            exp0.delete();
        end else begin
            check({tag, " count"}, act1.size(), exp1.size());
            while (act1.size() > 0 && exp1.size() > 0) check(tag, act1.pop_front(), exp1.pop_front());
            act1.delete();
            exp1.delete();
        end
    endtask

    int c0;
    int ovr_base;
    logic [8:0] d;
    bit flip;
    bit [1:0] sl;

    initial begin
        srst = 1'b1; rxd0 = 1'b1; rxd1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
        step(5);
        srst = 1'b0;
        step(2);
        check("rst data0", data0, 0);
        check("rst valid0", valid0, 0);
        check("rst frm0", frm0, 0);
        check("rst par0", par0, 0);
        check("rst ovr0", ovr0, 0);
        check("rst busy0", busy0, 0);
        check("rst valid1", valid1, 0);
        check("rst busy1", busy1, 0);

        // 0x55 8N1 with exact o_valid rise time
        c0 = cyc;
        send_frame(0, 9'h055, 8, 0, 1'b0, 2'b00, 1);
        exp0.push_back(pack(1'b0, 1'b0, 9'h055));
        check("t1 latency", rise0, c0 + T_DONE0);
        step(D0_BIT / 4);
        drain_check(0, "t1 word");

        // Overrun: two words with no consumer, then a ready pulse coinciding with a completion
        ready0 = 1'b0;
        ovr_base = ovr_cnt0;
        send_frame(0, 9'h012, 8, 0, 1'b0, 2'b00, 1);
        step(D0_BIT / 4);
        send_frame(0, 9'h034, 8, 0, 1'b0, 2'b00, 1);
        step(D0_BIT / 4);
        check("ovr held data", data0, 8'h12);
        check("ovr held valid", valid0, 1);
        check("ovr pulses", ovr_cnt0 - ovr_base, 1);
        exp0.push_back(pack(1'b0, 1'b0, 9'h012));
        c0 = cyc;
        fork
            send_frame(0, 9'h056, 8, 0, 1'b0, 2'b00, 1);
            begin
                wait_cyc(c0 + T_DONE0 - 1);
                ready0 = 1'b1;
                wait_cyc(c0 + T_DONE0);
                ready0 = 1'b0;
            end
        join
        check("same-cycle data", data0, 8'h56);
        check("same-cycle valid", valid0, 1);
        check("same-cycle no ovr", ovr_cnt0 - ovr_base, 1);
        ready0 = 1'b1;
        step(2);
        exp0.push_back(pack(1'b0, 1'b0, 9'h056));
        drain_check(0, "ovr words");

        // Short low glitch rejected, then a normal frame
        rxd0 = 1'b0;
        step(3 * D0_DIV);
        rxd0 = 1'b1;
        check("glitch busy", busy0, 1);
        step(D0_BIT);
        check("glitch idle", busy0, 0);
        drain_check(0, "glitch no word");
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b00, 1);
        exp0.push_back(pack(1'b0, 1'b0, 9'h0A5));
        step(D0_BIT / 4);
        drain_check(0, "after glitch");

        // Framing error, then reset in the middle of a frame whose tail is all ones
        send_frame(0, 9'h0C3, 8, 0, 1'b0, 2'b01, 1);
        exp0.push_back(pack(1'b1, 1'b0, 9'h0C3));
        step(D0_BIT);
        drain_check(0, "frm word");
        fork
            send_frame(0, 9'h0F0, 8, 0, 1'b0, 2'b00, 1);
            begin
                step(7 * D0_BIT + D0_BIT / 2);
                srst = 1'b1;
                step(1);
                srst = 1'b0;
                check("mid-rst data", data0, 0);
                check("mid-rst valid", valid0, 0);
                check("mid-rst frm", frm0, 0);
                check("mid-rst par", par0, 0);
                check("mid-rst ovr", ovr0, 0);
                check("mid-rst busy", busy0, 0);
            end
        join
        step(D0_BIT);
        drain_check(0, "aborted frame");
        send_frame(0, 9'h07E, 8, 0, 1'b0, 2'b00, 1);
        exp0.push_back(pack(1'b0, 1'b0, 9'h07E));
        step(D0_BIT / 4);
        drain_check(0, "after reset");

        // Line held low for two frame times
        ovr_base = ovr_cnt0;
`ifdef UART_RX_BREAK_DET_EN
        c0 = brk_cnt0;
`endif
        rxd0 = 1'b0;
        step(20 * D0_BIT);
        rxd0 = 1'b1;
        step(2 * D0_BIT);
`ifdef UART_RX_BREAK_DET_EN
        check("break pulses", brk_cnt0 - c0, 1);
`else
        exp0.push_back(pack(1'b1, 1'b0, 9'h000));
`endif
        check("long low no ovr", ovr_cnt0 - ovr_base, 0);
        drain_check(0, "long low");
        send_frame(0, 9'h031, 8, 0, 1'b0, 2'b00, 1);
        exp0.push_back(pack(1'b0, 1'b0, 9'h031));
        step(D0_BIT / 4);
        drain_check(0, "after long low");

        // 7E2 instance: directed parity pair, then randomized frames
        send_frame(1, 9'h041, 7, 2, 1'b0, 2'b00, 2);
        exp1.push_back(pack(1'b0, 1'b0, 9'h041));
        step(8);
        send_frame(1, 9'h041, 7, 2, 1'b1, 2'b00, 2);
        exp1.push_back(pack(1'b0, 1'b1, 9'h041));
        step(D1_BIT / 4);
        drain_check(1, "parity pair");
        for (int i = 0; i < 16; i++) begin
            d    = 9'($urandom_range(1, 127));
            flip = ($urandom_range(0, 3) == 0);
            sl   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            send_frame(1, d, 7, 2, flip, sl, 2);
            exp1.push_back(pack(|sl, flip, d));
            step($urandom_range(4, D1_BIT));
        end
        step(D1_BIT);
        drain_check(1, "random 7E2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
